// File: rtl/wb_sram_responder_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM responder.
package wb_sram_responder_pkg;

   localparam int WB_DATA_W   = 16;
   localparam int WB_SEL_BITS = 2;
   localparam int WB_ADDR_W   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BEAT = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      LEN_1 = 2'd0,
      LEN_4 = 2'd1,
      LEN_8 = 2'd2
   } burst_len_e;

   // Index of the final beat for each burst length.
   localparam logic [2:0] LAST_1 = 3'd0;
   localparam logic [2:0] LAST_4 = 3'd3;
   localparam logic [2:0] LAST_8 = 3'd7;

   // An 8-beat request wins when both flags are raised.
   function automatic burst_len_e decode_len(input logic b4, input logic b8);
      if (b8)
         return LEN_8;
      else if (b4)
         return LEN_4;
      else
         return LEN_1;
   endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Holds the burst start address, length and beat counter; produces the
// wrapped SRAM address of the current and the following beat.
module wb_burst_addr_gen
   import wb_sram_responder_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              load,
   input  logic [MEM_AW-1:0] start_addr,
   input  logic [1:0]        len_code,
   input  logic              advance,
   output logic [MEM_AW-1:0] cur_addr,
   output logic [MEM_AW-1:0] next_addr,
   output logic              last
);

   logic [MEM_AW-1:0] start_q;
   burst_len_e        len_q;
   logic [2:0]        cnt_q;
   logic [2:0]        cnt_nxt;

   // Address of beat k: only the low log2(L) bits move, so the burst
   // wraps inside its aligned block and keeps the upper bits.
   function automatic logic [MEM_AW-1:0] beat_addr(input logic [2:0] k);
      logic [MEM_AW-1:0] a;
      a = start_q;
      case (len_q)
         LEN_8:   a[2:0] = start_q[2:0] + k;
         LEN_4:   a[1:0] = start_q[1:0] + k[1:0];
         default: a = start_q;
      endcase
      return a;
   endfunction

   // Capture the burst on acceptance, then step once per completed beat.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         start_q <= '0;
         len_q   <= LEN_1;
         cnt_q   <= '0;
      end else if (load) begin
         start_q <= start_addr;
         len_q   <= burst_len_e'(len_code);
         cnt_q   <= '0;
      end else if (advance) begin
         cnt_q   <= cnt_nxt;
      end
   end

   // Current/next beat addresses and the final-beat flag.
   always_comb begin
      cnt_nxt   = cnt_q + 3'd1;
      cur_addr  = beat_addr(cnt_q);
      next_addr = beat_addr(cnt_nxt);
      case (len_q)
         LEN_8:   last = (cnt_q == LAST_8);
         LEN_4:   last = (cnt_q == LAST_4);
         default: last = (cnt_q == LAST_1);
      endcase
   end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone responder serving single and 4/8-beat wrapping bursts from a
// single-port synchronous SRAM; out-of-window requests get wb_err.
module wb_sram_responder
   import wb_sram_responder_pkg::*;
#(
   parameter int ADDR_W = WB_ADDR_W,
   parameter int MEM_AW = 10,
   parameter int BASE   = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   wb_cyc,
   input  logic                   wb_stb,
   input  logic                   wb_we,
   input  logic [ADDR_W-1:0]      wb_adr,
   input  logic [WB_DATA_W-1:0]   wb_i_dat,
   input  logic [WB_SEL_BITS-1:0] wb_sel,
   input  logic                   wb_4_burst,
   input  logic                   wb_8_burst,
   output logic [WB_DATA_W-1:0]   wb_o_dat,
   output logic                   wb_ack,
   output logic                   wb_err,
   output logic                   wb_rty,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [WB_SEL_BITS-1:0] mem_wmask,
   output logic [MEM_AW-1:0]      mem_addr,
   output logic [WB_DATA_W-1:0]   mem_wdata,
   input  logic [WB_DATA_W-1:0]   mem_rdata
);

   localparam int HI_W = ADDR_W - MEM_AW;
   localparam logic [HI_W-1:0] BASE_HI = HI_W'(BASE);

   state_e            state_q;
   state_e            state_d;
   logic              we_q;
   logic              req;
   logic              hit;
   logic              load;
   logic              advance;
   logic [MEM_AW-1:0] cur_addr;
   logic [MEM_AW-1:0] next_addr;
   logic              last;
   burst_len_e        len_req;

   assign req     = wb_cyc & wb_stb;
   assign hit     = (wb_adr[ADDR_W-1:MEM_AW] == BASE_HI);
   assign load    = (state_q == ST_IDLE) & req & hit;
   assign advance = (state_q == ST_BEAT) & wb_cyc;
   assign len_req = decode_len(wb_4_burst, wb_8_burst);
   assign wb_rty  = 1'b0;

   wb_burst_addr_gen #(
      .MEM_AW(MEM_AW)
   ) u_addr_gen (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .load      (load),
      .start_addr(wb_adr[MEM_AW-1:0]),
      .len_code  (len_req),
      .advance   (advance),
      .cur_addr  (cur_addr),
      .next_addr (next_addr),
      .last      (last)
   );

   // State register plus the direction latched at acceptance.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load)
            we_q <= wb_we;
      end
   end

   // Next state: a dropped wb_cyc aborts a burst straight back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req)
               state_d = hit ? ST_BEAT : ST_ERR;
         end
         ST_BEAT: begin
            if (!wb_cyc || last)
               state_d = ST_IDLE;
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus and SRAM outputs; everything is forced low while reset is held,
   // including the combinational read issue in IDLE.
   always_comb begin
      wb_o_dat  = '0;
      wb_ack    = 1'b0;
      wb_err    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_wmask = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (i_rst) begin
         case (state_q)
            ST_IDLE: begin
               // Issue the first read now so data is ready on the first beat.
               if (req && hit && !wb_we) begin
                  mem_en   = 1'b1;
                  mem_addr = wb_adr[MEM_AW-1:0];
               end
            end
            ST_BEAT: begin
               if (wb_cyc) begin
                  wb_ack = 1'b1;
                  if (we_q) begin
                     mem_en    = 1'b1;
                     mem_we    = 1'b1;
                     mem_wmask = wb_sel;
                     mem_addr  = cur_addr;
                     mem_wdata = wb_i_dat;
                  end else begin
                     wb_o_dat = mem_rdata;
                     // Prefetch the following beat unless this is the last.
                     if (!last) begin
                        mem_en   = 1'b1;
                        mem_addr = next_addr;
                     end
                  end
               end
            end
            ST_ERR:  wb_err = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Scoreboard bench for wb_sram_responder with a behavioural SRAM model.
module tb_wb_sram_responder;

   localparam int ADDR_W = 16;
   localparam int MEM_AW = 10;
   localparam int BASE   = 3;

   typedef struct packed {
      logic        is_err;
      logic        chk;
      logic [15:0] dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we, b4, b8;
   logic [15:0] adr;
   logic [15:0] dat;
   logic [1:0]  sel;
   logic [15:0] o_dat;
   logic        ack, err, rty;
   logic        mem_en, mem_we;
   logic [1:0]  mem_wmask;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic [15:0] mem [1024];
   exp_t        sb [$];
   int          tests = 0;
   int          failed = 0;
   int          en_cnt = 0;
   int          err_cnt = 0;

   always #5 clk = ~clk;

   wb_sram_responder #(
      .ADDR_W(ADDR_W),
      .MEM_AW(MEM_AW),
      .BASE  (BASE)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst_n),
      .wb_cyc    (cyc),
      .wb_stb    (stb),
      .wb_we     (we),
      .wb_adr    (adr),
      .wb_i_dat  (dat),
      .wb_sel    (sel),
      .wb_4_burst(b4),
      .wb_8_burst(b8),
      .wb_o_dat  (o_dat),
      .wb_ack    (ack),
      .wb_err    (err),
      .wb_rty    (rty),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_wmask (mem_wmask),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Synchronous single-port SRAM with byte write mask.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            if (mem_wmask[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
            if (mem_wmask[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic is_err, input logic c, input logic [15:0] d);
      exp_t e;
      e.is_err = is_err;
      e.chk    = c;
      e.dat    = d;
      sb.push_back(e);
   endtask

   function automatic logic [15:0] wadr(input logic [9:0] off);
      return {6'(BASE), off};
   endfunction

   // Monitor: every ack/err pops one expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) en_cnt++;
         if (err) err_cnt++;
         if (ack && err) begin
            tests++;
            failed++;
            $display("FAIL ack_err_both: ack=%0b err=%0b", ack, err);
         end
         if (ack || err) begin
            if (sb.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL unexpected_resp: ack=%0b err=%0b dat=%0h at %0t", ack, err, o_dat, $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_kind_err", 32'(err), 32'(e.is_err));
               if (e.chk) chk("sb_rdata", 32'(o_dat), 32'(e.dat));
            end
         end
      end
   end

   task automatic single(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] s, input logic f4, input logic f8);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; b4 = f4; b8 = f8;
      @(posedge clk); #1;
      chk("latency_1cyc", 32'(ack | err), 32'd1);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; b4 = 1'b0; b8 = 1'b0;
   endtask

   task automatic burst_read(input logic [15:0] a, input logic f4, input logic f8, input int n);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; b4 = f4; b8 = f8;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk("burst_ack", 32'(ack), 32'd1);
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; b4 = 1'b0; b8 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] e8a [8];
      logic [15:0] e4  [4];
      logic [15:0] e8b [8];
      e8a = '{16'hC1A3, 16'hC1A4, 16'hC1A5, 16'hC1A6, 16'hC1A7, 16'hC1A0, 16'hC1A1, 16'hC1A2};
      e4  = '{16'hC1A6, 16'hC1A7, 16'hC1A4, 16'hC1A5};
      e8b = '{16'hC0FE, 16'hC0FF, 16'hC0F8, 16'hC0F9, 16'hC0FA, 16'hC0FB, 16'hC0FC, 16'hC0FD};
      for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 | 16'(i);
      mem_rdata = '0;

      // Reset with a valid in-window read presented: outputs must stay low.
      rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = wadr(10'h010);
      dat = '0; sel = '0; b4 = 1'b0; b8 = 1'b0;
      #12;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_odat", 32'(o_dat), 32'd0);
      chk("rty_zero", 32'(rty), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single write then read back; partial byte write.
      push(1'b0, 1'b0, 16'h0);
      single(1'b1, wadr(10'h010), 16'hBEEF, 2'b11, 1'b0, 1'b0);
      chk("mem_010", 32'(mem[10'h010]), 32'h0000BEEF);
      push(1'b0, 1'b1, 16'hBEEF);
      single(1'b0, wadr(10'h010), 16'h0, 2'b00, 1'b0, 1'b0);
      push(1'b0, 1'b0, 16'h0);
      single(1'b1, wadr(10'h010), 16'h1234, 2'b01, 1'b0, 1'b0);
      push(1'b0, 1'b1, 16'hBE34);
      single(1'b0, wadr(10'h010), 16'h0, 2'b00, 1'b0, 1'b0);

      // Wrapping bursts: 8-beat, 4-beat, both flags set.
      for (int i = 0; i < 8; i++) push(1'b0, 1'b1, e8a[i]);
      burst_read(wadr(10'h1A3), 1'b0, 1'b1, 8);
      for (int i = 0; i < 4; i++) push(1'b0, 1'b1, e4[i]);
      burst_read(wadr(10'h1A6), 1'b1, 1'b0, 4);
      for (int i = 0; i < 8; i++) push(1'b0, 1'b1, e8b[i]);
      burst_read(wadr(10'h0FE), 1'b1, 1'b1, 8);

      // 4-beat write aborted after the second ack.
      push(1'b0, 1'b0, 16'h0);
      push(1'b0, 1'b0, 16'h0);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = wadr(10'h040); dat = 16'h1111; sel = 2'b11; b4 = 1'b1;
      @(posedge clk); #1;
      chk("abort_ack0", 32'(ack), 32'd1);
      @(posedge clk); #1;
      dat = 16'h2222;
      chk("abort_ack1", 32'(ack), 32'd1);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; dat = 16'h3333;
      #1;
      chk("abort_no_ack", 32'(ack), 32'd0);
      chk("abort_no_write", 32'(mem_en), 32'd0);
      push(1'b0, 1'b1, 16'h1111);
      single(1'b0, wadr(10'h040), 16'h0, 2'b00, 1'b0, 1'b0);
      push(1'b0, 1'b1, 16'h2222);
      single(1'b0, wadr(10'h041), 16'h0, 2'b00, 1'b0, 1'b0);
      push(1'b0, 1'b1, 16'hC042);
      single(1'b0, wadr(10'h042), 16'h0, 2'b00, 1'b0, 1'b0);

      // Out-of-window single and 8-burst: one err each, no SRAM access.
      en_cnt = 0; err_cnt = 0;
      push(1'b1, 1'b0, 16'h0);
      single(1'b0, 16'h1010, 16'h0, 2'b00, 1'b0, 1'b0);
      push(1'b1, 1'b0, 16'h0);
      single(1'b0, 16'h1010, 16'h0, 2'b00, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("err_count", 32'(err_cnt), 32'd2);
      chk("err_no_mem_en", 32'(en_cnt), 32'd0);

      // Reset in the third beat of an 8-burst read.
      push(1'b0, 1'b1, 16'hC100);
      push(1'b0, 1'b1, 16'hC101);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = wadr(10'h100); b8 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_mem_en", 32'(mem_en), 32'd0);
      chk("midrst_odat", 32'(o_dat), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("inrst_mem_en", 32'(mem_en), 32'd0);
      cyc = 1'b0; stb = 1'b0; b8 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push(1'b0, 1'b1, 16'hC105);
      single(1'b0, wadr(10'h105), 16'h0, 2'b00, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
